// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sequencer that shares one mem_sys port.
// One operation in flight; a grant in RESP overlaps with the response.
package mem_arbiter_pkg;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] offset;
    logic [31:0] data;
    logic [1:0]  mode;
  } mem_in_bus_t;

  localparam mem_in_bus_t IDLE_BUS = '0;

endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  mem_in_bus_t       req_bus [NREQ],
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_data,
  output mem_in_bus_t       mem_bus,
  input  logic [31:0]       mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_last_grant;
  logic [IDX_W-1:0]  r_cur;
  logic [1:0]        r_cur_mode;
  mem_in_bus_t       r_mem_bus;

  logic              w_found;
  logic [IDX_W-1:0]  w_gidx;
  logic              w_grant;
  logic              w_has_data;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("mem_arbiter: NREQ must be in 2..8");
  end

  // Scan from the requester after the last grant, wrapping around.
  always_comb begin
    int v;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v = (int'(r_last_grant) + k) % NREQ;
      if (!w_found && req_valid[v[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = v[IDX_W-1:0];
      end
    end
  end

  assign w_grant = reset && w_found && (r_state != S_ISSUE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = w_grant ? S_ISSUE : S_IDLE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = w_grant ? S_ISSUE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= LAST_RST;
      r_cur        <= '0;
      r_cur_mode   <= 2'b00;
      r_mem_bus    <= IDLE_BUS;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_mem_bus    <= req_bus[w_gidx];
        r_cur        <= w_gidx;
        r_cur_mode   <= req_bus[w_gidx].mode;
        r_last_grant <= w_gidx;
      end else begin
        r_mem_bus    <= IDLE_BUS;
      end
    end
  end

  // Reads and allocs return data; writes and rebases are bare acks.
  assign w_has_data = (r_cur_mode == 2'b00) || (r_cur_mode == 2'b10);

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    if (w_grant) begin
      req_ready[w_gidx] = 1'b1;
    end
    if (reset && r_state == S_RESP) begin
      resp_valid[r_cur] = 1'b1;
      if (w_has_data) begin
        resp_data = mem_data_out;
      end
    end
  end

  assign mem_bus = r_mem_bus;
  assign busy    = (r_state != S_IDLE);

  a_ready_onehot : assert property (
    @(posedge clk) disable iff (!reset) $onehot0(req_ready));

  a_resp_onehot : assert property (
    @(posedge clk) disable iff (!reset) $onehot0(resp_valid));

  a_issue_noready : assert property (
    @(posedge clk) disable iff (!reset)
    (r_state == S_ISSUE) |-> (req_ready == '0));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a behavioural mem_sys stand-in.
// Per-scenario tasks check timing inline; a monitor checks responses.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  mem_in_bus_t       req_bus [NREQ];
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [31:0]       resp_data;
  mem_in_bus_t       mem_bus;
  logic [31:0]       mem_data_out;
  logic              busy;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_bus      (req_bus),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .mem_bus      (mem_bus),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  // mem_sys stand-in: executes whatever mem_bus carries at each edge.
  logic [31:0] mm [0:511];
  logic [31:0] heap;
  logic [31:0] zbase;
  logic [31:0] ea;

  always_comb begin
    ea = ((mem_bus.address == 32'h0) ? zbase : mem_bus.address)
         + mem_bus.offset;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) mm[i] <= 32'h0;
      mm[9'h020]   <= 32'hDEADBEEF;
      mm[9'h102]   <= 32'hCAFE0102;
      heap         <= 32'h10;
      zbase        <= 32'h0;
      mem_data_out <= 32'h0;
    end else begin
      case (mem_bus.mode)
        2'b00: mem_data_out <= mm[ea[8:0]];
        2'b01: begin
          mm[ea[8:0]]  <= mem_bus.data;
          mem_data_out <= mem_bus.data;
        end
        2'b10: begin
          mem_data_out <= heap;
          heap         <= heap + mem_bus.offset;
        end
        default: begin
          zbase        <= mem_bus.address;
          mem_data_out <= mem_bus.data;
        end
      endcase
    end
  end

  exp_t            mon_e;
  logic [NREQ-1:0] mon_oh;

  always @(negedge clk) begin
    if (reset) begin
      n_tests++;
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_resp: resp_valid=%b data=%h, none expected",
                   resp_valid, resp_data);
        end else begin
          mon_e  = sb.pop_front();
          mon_oh = '0;
          mon_oh[mon_e.idx] = 1'b1;
          if (resp_valid !== mon_oh || resp_data !== mon_e.data) begin
            n_fail++;
            $display("FAIL sb_resp: got valid=%b data=%h, want valid=%b data=%h",
                     resp_valid, resp_data, mon_oh, mon_e.data);
          end
        end
      end else if (resp_data !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_resp_data: got %h, want 0", resp_data);
      end
    end
  end

  function automatic mem_in_bus_t mk(input logic [31:0] a,
                                     input logic [31:0] o,
                                     input logic [31:0] d,
                                     input logic [1:0]  m);
    mem_in_bus_t b;
    b.address = a;
    b.offset  = o;
    b.data    = d;
    b.mode    = m;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) req_bus[i] = IDLE_BUS;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
      sb.delete();
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    step();
    @(negedge clk);
    n_tests++;
    if (req_ready !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready_busy: got ready=%b busy=%b, want 00 0",
               req_ready, busy);
    end
    n_tests++;
    if (mem_bus !== IDLE_BUS || resp_valid !== '0 || resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_outputs: got bus=%h rv=%b rd=%h, want idle/0/0",
               mem_bus, resp_valid, resp_data);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    mem_in_bus_t rd;
    apply_reset();
    rd = mk(32'h20, 32'h0, 32'h0, 2'b00);
    req_bus[0] = rd;
    req_valid  = 2'b01;
    sb.push_back('{0, 32'hDEADBEEF});
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_ready: got %b, want 01", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (mem_bus !== rd || busy !== 1'b1 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL rd_issue: got bus=%h busy=%b ready=%b, want %h 1 00",
               mem_bus, busy, req_ready, rd);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (resp_valid !== 2'b01 || mem_bus !== IDLE_BUS) begin
      n_fail++;
      $display("FAIL rd_resp_cycle: got rv=%b bus=%h, want 01 idle",
               resp_valid, mem_bus);
    end
    drain(10);
  endtask

  task automatic test_write_read();
    mem_in_bus_t wr;
    mem_in_bus_t rd;
    apply_reset();
    wr = mk(32'h40, 32'h4, 32'h1234, 2'b01);
    rd = mk(32'h40, 32'h4, 32'h0, 2'b00);
    req_bus[1] = wr;
    req_valid  = 2'b10;
    sb.push_back('{1, 32'h0});
    sb.push_back('{1, 32'h1234});
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_ready: got %b, want 10", req_ready);
    end
    step();
    req_bus[1] = rd;
    @(negedge clk);
    n_tests++;
    if (req_ready !== '0 || mem_bus !== wr) begin
      n_fail++;
      $display("FAIL wr_issue: got ready=%b bus=%h, want 00 %h",
               req_ready, mem_bus, wr);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b10 || resp_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL rd_grant_in_resp: got ready=%b rv=%b, want 10 10",
               req_ready, resp_valid);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (mem_bus !== rd) begin
      n_fail++;
      $display("FAIL rd_after_wr_bus: got %h, want %h", mem_bus, rd);
    end
    drain(10);
  endtask

  task automatic test_contention();
    int grants;
    logic [NREQ-1:0] want;
    apply_reset();
    req_bus[0] = mk(32'h0, 32'h8, 32'h0, 2'b10);
    req_bus[1] = mk(32'h0, 32'h8, 32'h0, 2'b10);
    req_valid  = 2'b11;
    sb.push_back('{0, 32'h10});
    sb.push_back('{1, 32'h18});
    sb.push_back('{0, 32'h20});
    sb.push_back('{1, 32'h28});
    grants = 0;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        want = '0;
        want[grants % 2] = 1'b1;
        n_tests++;
        if (req_ready !== want) begin
          n_fail++;
          $display("FAIL rr_grant%0d: got %b, want %b", grants, req_ready, want);
        end
        grants++;
      end
      step();
    end
    req_valid = '0;
    n_tests++;
    if (grants != 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants, want 4", grants);
    end
    drain(12);
  endtask

  task automatic test_mode11();
    apply_reset();
    req_bus[0] = mk(32'h100, 32'h0, 32'h5555, 2'b11);
    req_valid  = 2'b01;
    sb.push_back('{0, 32'h0});
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL zr_ready: got %b, want 01", req_ready);
    end
    step();
    req_bus[0] = mk(32'h0, 32'h2, 32'h0, 2'b00);
    sb.push_back('{0, 32'hCAFE0102});
    step();
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL zr_read_ready: got %b, want 01", req_ready);
    end
    step();
    req_valid = '0;
    drain(10);
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    req_bus[0] = mk(32'h20, 32'h0, 32'h0, 2'b00);
    req_bus[1] = mk(32'h20, 32'h0, 32'h0, 2'b00);
    req_valid  = 2'b01;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_ready: got %b, want 01", req_ready);
    end
    step();
    req_valid = 2'b11;
    reset     = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || mem_bus !== IDLE_BUS || resp_valid !== '0) begin
      n_fail++;
      $display("FAIL mid_async: got busy=%b bus=%h rv=%b, want 0 idle 00",
               busy, mem_bus, resp_valid);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if (resp_valid !== '0 || req_ready !== '0 || busy !== 1'b0 ||
          mem_bus !== IDLE_BUS) begin
        n_fail++;
        $display("FAIL mid_held%0d: got rv=%b ready=%b busy=%b bus=%h",
                 i, resp_valid, req_ready, busy, mem_bus);
      end
    end
    req_valid = 2'b10;
    step();
    reset = 1'b1;
    sb.push_back('{1, 32'hDEADBEEF});
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL post_rst_req1: got %b, want 10", req_ready);
    end
    step();
    req_valid = '0;
    drain(10);
    reset = 1'b0;
    step();
    req_valid = 2'b11;
    step();
    reset = 1'b1;
    sb.push_back('{0, 32'hDEADBEEF});
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL post_rst_both: got %b, want 01", req_ready);
    end
    step();
    req_valid = '0;
    drain(10);
  endtask

  task automatic test_hold();
    mem_in_bus_t wr;
    mem_in_bus_t rd;
    apply_reset();
    wr = mk(32'h60, 32'h0, 32'h77, 2'b01);
    rd = mk(32'h20, 32'h0, 32'h0, 2'b00);
    req_bus[0] = wr;
    req_bus[1] = mk(32'h44, 32'h0, 32'h0, 2'b00);
    req_valid  = 2'b11;
    sb.push_back('{0, 32'h0});
    sb.push_back('{1, 32'hDEADBEEF});
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_first: got %b, want 01", req_ready);
    end
    step();
    req_valid  = 2'b10;
    req_bus[1] = rd;
    @(negedge clk);
    n_tests++;
    if (mem_bus !== wr) begin
      n_fail++;
      $display("FAIL hold_issue_bus: got %h, want %h", mem_bus, wr);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_second: got %b, want 10", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_tests++;
    if (mem_bus !== rd) begin
      n_fail++;
      $display("FAIL hold_sampled_bus: got %h, want %h", mem_bus, rd);
    end
    drain(10);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) req_bus[i] = IDLE_BUS;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_mode11();
    test_reset_mid_op();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
